// File: rtl/freq_meter_if.sv
// Bus between freq_meter and its user: enable/signal in, measurement results out.
// With FREQ_METER_PERIOD_EN defined, the period result signals are added.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 24
) ();
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_out;
    logic             valid;
    logic             ovf;
    logic             busy;
`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] period_out;
    logic             period_valid;

    modport master (
        output en, sig_in,
        input  freq_out, valid, ovf, busy, period_out, period_valid
    );
    modport slave (
        input  en, sig_in,
        output freq_out, valid, ovf, busy, period_out, period_valid
    );
`else
    modport master (
        output en, sig_in,
        input  freq_out, valid, ovf, busy
    );
    modport slave (
        input  en, sig_in,
        output freq_out, valid, ovf, busy
    );
`endif
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a GATE_CYCLES-long window of clk.
// Optional FREQ_METER_PERIOD_EN adds a clk-cycle period measurement between edges.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 12000000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic         clk,
    input  logic         rst,
    freq_meter_if.slave  bus
);
    localparam int unsigned     GW   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX  = '1;

    typedef enum logic {StIdle, StGate} state_t;

    logic             r_s1, r_s2, r_s3;
    state_t           r_state;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_freq;
    logic             r_valid;
    logic             r_ovf;
    logic             r_busy;

    logic             w_edge;
    logic             w_at_max;
    logic             w_clip;
    logic             w_last;
    logic [CNT_W-1:0] w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge   = r_s2 & ~r_s3;
    assign w_at_max = (r_edge_cnt == MAX);
    // An edge arriving at full scale is clipped and marks the window as overflowed.
    assign w_clip   = w_edge & w_at_max;
    assign w_sum    = (w_edge && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_last   = (r_gate_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_sat      <= 1'b0;
                    if (bus.en) begin
                        r_state <= StGate;
                        r_busy  <= 1'b1;
                    end
                end
                StGate: begin
                    if (w_last) begin
                        // Window closes even if en drops now; the result still lands.
                        r_freq     <= w_sum;
                        r_ovf      <= r_sat | w_clip;
                        r_valid    <= 1'b1;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                        if (!bus.en) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else if (!bus.en) begin
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_sat      <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                        r_edge_cnt <= w_sum;
                        r_sat      <= r_sat | w_clip;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.freq_out = r_freq;
    assign bus.valid    = r_valid;
    assign bus.ovf      = r_ovf;
    assign bus.busy     = r_busy;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] r_per_cnt;
    logic             r_armed;
    logic [CNT_W-1:0] r_period;
    logic             r_pvalid;

    // The first edge after entering the gate only arms the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_armed   <= 1'b0;
            r_period  <= '0;
            r_pvalid  <= 1'b0;
        end else begin
            r_pvalid <= 1'b0;
            if (r_state != StGate) begin
                r_per_cnt <= '0;
                r_armed   <= 1'b0;
            end else if (w_edge) begin
                if (r_armed) begin
                    r_period <= r_per_cnt;
                    r_pvalid <= 1'b1;
                end
                r_per_cnt <= CNT_W'(1);
                r_armed   <= 1'b1;
            end else if (r_armed && (r_per_cnt != MAX)) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.period_out   = r_period;
    assign bus.period_valid = r_pvalid;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (24-bit and 4-bit result) share one stimulus and
// are checked every cycle against an edge-counting model plus directed literal checks.
module tb_freq_meter;
    localparam int unsigned G     = 100;
    localparam int unsigned MAX_A = 24'hFFFFFF;
    localparam int unsigned MAX_B = 15;

    logic clk;
    logic rst;
    logic en;
    logic sig_in;

    freq_meter_if #(.CNT_W(24)) if_a ();
    freq_meter_if #(.CNT_W(4))  if_b ();

    assign if_a.en     = en;
    assign if_a.sig_in = sig_in;
    assign if_b.en     = en;
    assign if_b.sig_in = sig_in;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(24)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    freq_meter #(.GATE_CYCLES(G), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned satv(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Model: edges are what a two-flop sampler plus a history sample would see; each
    // window is G clk edges and reports the true count clipped to the result width.
    bit          h0, h1, h2, m_e;
    bit          m_gate;
    int unsigned m_pos, m_cnt, m_tot, m_n, m_last;
    bit          m_armed;
    logic [23:0] ea_freq, ea_per;
    logic [3:0]  eb_freq, eb_per;
    bit          e_valid, ea_ovf, eb_ovf, e_pval;

    task automatic model_step();
        if (rst) begin
            {h0, h1, h2} = 3'b000;
            m_gate = 0; m_pos = 0; m_cnt = 0; m_armed = 0; m_n = 0; m_last = 0;
            ea_freq = '0; eb_freq = '0; ea_ovf = 0; eb_ovf = 0; e_valid = 0;
            ea_per = '0; eb_per = '0; e_pval = 0;
            return;
        end
        m_n++;
        m_e = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = sig_in;
        e_valid = 0;
        e_pval  = 0;
        if (m_gate) begin
            if (m_e) begin
                if (m_armed) begin
                    ea_per = 24'(satv(m_n - m_last, MAX_A));
                    eb_per = 4'(satv(m_n - m_last, MAX_B));
                    e_pval = 1;
                end
                m_last  = m_n;
                m_armed = 1;
            end
            if (m_pos == G - 1) begin
                m_tot   = m_cnt + m_e;
                ea_freq = 24'(satv(m_tot, MAX_A));
                eb_freq = 4'(satv(m_tot, MAX_B));
                ea_ovf  = m_tot > MAX_A;
                eb_ovf  = m_tot > MAX_B;
                e_valid = 1;
                m_pos   = 0;
                m_cnt   = 0;
                m_gate  = en;
            end else if (!en) begin
                m_gate = 0;
            end else begin
                m_pos++;
                m_cnt += m_e;
            end
        end else if (en) begin
            m_gate = 1; m_pos = 0; m_cnt = 0; m_armed = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            check("a_freq",  if_a.freq_out, ea_freq);
            check("a_valid", if_a.valid,    e_valid);
            check("a_ovf",   if_a.ovf,      ea_ovf);
            check("a_busy",  if_a.busy,     m_gate);
            check("b_freq",  if_b.freq_out, eb_freq);
            check("b_valid", if_b.valid,    e_valid);
            check("b_ovf",   if_b.ovf,      eb_ovf);
            check("b_busy",  if_b.busy,     m_gate);
`ifdef FREQ_METER_PERIOD_EN
            check("a_period",  if_a.period_out,   ea_per);
            check("a_pvalid",  if_a.period_valid, e_pval);
            check("b_period",  if_b.period_out,   eb_per);
            check("b_pvalid",  if_b.period_valid, e_pval);
`endif
        end
    end

    // Stimulus: sig_in is a square wave of period per (0 = hold lvl), updated on negedges.
    int per = 0;
    int ph  = 0;
    bit lvl = 0;

    task automatic cyc();
        @(negedge clk);
        ph++;
        sig_in = (per != 0) ? ((ph % per) < (per / 2)) : lvl;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!if_a.valid && n < 300);
        if (!if_a.valid) check("valid_timeout", {31'b0, if_a.valid}, 1);
    endtask

    int n, nv;

    initial begin
        rst = 1'b1; en = 1'b0; sig_in = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (5) cyc();
        check("idle_busy",  if_a.busy,     0);
        check("idle_freq",  if_a.freq_out, 0);
        check("idle_valid", if_a.valid,    0);

        // Basic count: period 10 -> 10 edges per 100-cycle window.
        per = 10;
        repeat (5) cyc();
        en = 1'b1;
        wait_valid(n);
        check("first_valid_lat", n, 101);
        check("basic_freq_a", if_a.freq_out, 10);
        check("basic_freq_b", if_b.freq_out, 10);
        check("basic_ovf_a",  if_a.ovf,      0);
        wait_valid(n);
        check("b2b_period", n, 100);
        check("b2b_freq",   if_a.freq_out, 10);

        // Abort at gate_cnt 50.
        repeat (50) cyc();
        en = 1'b0;
        cyc();
        check("abort_busy", if_a.busy,     0);
        check("abort_hold", if_a.freq_out, 10);
        nv = 0;
        repeat (30) begin
            cyc();
            if (if_a.valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        en = 1'b1;
        wait_valid(n);
        check("restart_lat",  n, 101);
        check("restart_freq", if_a.freq_out, 10);

        // en dropped on the closing cycle: result still latched.
        repeat (99) cyc();
        en = 1'b0;
        cyc();
        check("close_en0_valid", if_a.valid,    1);
        check("close_en0_freq",  if_a.freq_out, 10);
        cyc();
        check("close_en0_busy",  if_a.busy,     0);

        // Saturation: period 2 -> 50 edges.
        per = 2;
        repeat (4) cyc();
        en = 1'b1;
        wait_valid(n);
        check("sat_freq_a", if_a.freq_out, 50);
        check("sat_ovf_a",  if_a.ovf,      0);
        check("sat_freq_b", if_b.freq_out, 15);
        check("sat_ovf_b",  if_b.ovf,      1);
        per = 0; lvl = 0;
        wait_valid(n);
        wait_valid(n);
        check("low_freq_b", if_b.freq_out, 0);
        check("low_ovf_b",  if_b.ovf,      0);

        // Boundary: rise detected on the last window cycle counts in that window.
        repeat (96) cyc();
        lvl = 1;
        cyc();
        wait_valid(n);
        check("bound_lat",    n, 3);
        check("bound_freq_a", if_a.freq_out, 1);
        check("bound_freq_b", if_b.freq_out, 1);
        wait_valid(n);
        check("bound_next",   if_a.freq_out, 0);
        lvl = 0;

        // Reset mid-window clears outputs at once.
        per = 10;
        wait_valid(n);
        wait_valid(n);
        check("pre_rst_freq", if_a.freq_out, 10);
        repeat (40) cyc();
        #2 rst = 1'b1;
        #1;
        check("rst_freq", if_a.freq_out, 0);
        check("rst_busy", if_a.busy,     0);
        check("rst_ovf",  if_b.ovf,      0);
        en = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        check("post_rst_busy", if_a.busy, 0);

`ifdef FREQ_METER_PERIOD_EN
        per = 7;
        repeat (3) cyc();
        en = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!if_a.period_valid && n < 100);
        check("per_pvalid", if_a.period_valid, 1);
        check("per_val_a",  if_a.period_out,   7);
        check("per_val_b",  if_b.period_out,   7);
        repeat (30) cyc();
        en = 1'b0;
`endif
        repeat (5) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external square-wave input by counting its rising edges over a fixed gate window of clk cycles.
- Inverse of the board clock divider: the divider turns the 12 MHz clk into slow ticks; this block turns an unknown slow signal back into a number (edges per window).
- Sits between board I/O (a divider output looped back, or an external pin) and the display/LED logic.
- Default gate of 12,000,000 cycles gives a 1 s window at 12 MHz, so the result reads directly in Hz.

Parameters:
- GATE_CYCLES, 12000000, window length in clk cycles; must be >= 2.
- CNT_W, 24, width of the edge counter and of the result.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  measurement enable, synchronous to clk.
- sig_in  input  1  measured signal, asynchronous to clk.
- freq_out  output  CNT_W  rising-edge count from the last completed window.
- valid  output  1  one-cycle pulse when freq_out updates.
- ovf  output  1  last completed window saturated.
- busy  output  1  high while in GATE.

Behaviour:
- Reset (async, rst=1): state=IDLE; freq_out=0, valid=0, ovf=0, busy=0; sync flops, gate counter and edge counter all cleared.
- Input path:
  - sig_in passes through a 2-flop synchronizer s1->s2, then a history flop s3.
  - edge = s2 & ~s3.
  - Latency: a sig_in rise is counted 3 clk edges after it occurs (plus up to 1 cycle of sampling uncertainty).
- States:
  - IDLE: counters held at 0, busy=0. en=1 -> GATE next cycle, gate_cnt=0, edge_cnt=0.
  - GATE: busy=1; gate_cnt increments every cycle.
    - edge=1 adds 1 to edge_cnt, saturating at 2^CNT_W-1.
    - Saturation sets an internal sat flag for the current window.
  - End of window: when gate_cnt==GATE_CYCLES-1, on the next clk edge:
    - freq_out <= edge_cnt + edge (saturated).
    - ovf <= sat, or the final add saturates.
    - valid=1 for exactly that one cycle.
    - gate_cnt, edge_cnt and sat clear; state stays GATE, so back-to-back windows run with no dead cycle.
  - en deasserted while in GATE: window aborted. Next state is IDLE; freq_out and ovf hold their previous values; no valid pulse.
- Boundary cases:
  - Edge on the last window cycle counts in the closing window.
  - Edge on the first cycle after a window closes counts in the new window.
  - en=0 on the same cycle the window completes: result is latched and valid pulses, then the block goes to IDLE.
  - Constant sig_in: freq_out=0 after each window.
  - Maximum measurable rate: clk/2 (one edge per 2 cycles).
  - Reset mid-window: everything clears immediately; no valid pulse.
- Width rules:
  - gate_cnt is wide enough for GATE_CYCLES-1, computed with $clog2.
  - All additions are unsigned, with no wrap.

Optional Feature:
- Macro: FREQ_METER_PERIOD_EN.
- Defined: adds output period_out (CNT_W) and output period_valid (1).
  - A free-running counter counts clk cycles between consecutive detected edges.
  - On each edge: period_out <= count since the previous edge, then the counter restarts at 1.
  - period_valid pulses for 1 cycle on each update.
  - The first edge after reset, or after leaving IDLE, only arms the counter and gives no pulse.
  - The counter saturates at 2^CNT_W-1.
  - Runs only in GATE; cleared in IDLE and on rst.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 during activity -> all outputs 0 the same cycle; rst=0 with en=0 -> state stays IDLE, busy=0.
- Basic count (GATE_CYCLES=100): en=1, sig_in period 10 clk, 50% duty -> valid every 100 cycles, freq_out=10, ovf=0; first valid on cycle 101 after en rises.
- Boundary edge (GATE_CYCLES=100): sig_in rise timed so the detected edge lands on gate_cnt=99 -> counted in that window (e.g. 1, not 0); next window unaffected.
- Saturation (CNT_W=4, GATE_CYCLES=100): sig_in period 2 clk (50 edges) -> freq_out=15, ovf=1; then sig_in held low -> next window freq_out=0, ovf=0.
- Abort: en=0 at gate_cnt=50 after one completed window with freq_out=10 -> busy=0 next cycle, freq_out stays 10, no valid pulse; en=1 again -> new full 100-cycle window.
- FREQ_METER_PERIOD_EN: sig_in period 7 clk -> after the second edge, period_out=7 with a 1-cycle period_valid per edge; no pulse on the first edge.
